riscv_hazard_ctrl_p: RTL and testbench

RISCV_HAZARD_CTRL_P -- requirements
Module: riscv_hazard_ctrl_p

---
 rtl/riscv_hazard_ctrl_p.sv | 124 ++++++++++++
 tb/tb_riscv_hazard_ctrl_p.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_ctrl_p.sv
// Hazard controller for a 5-stage RISC-V pipeline: a shadow pipeline of EX/MEM/WB
// destination info drives stall/flush/hold, operand forwarding and multicycle EX occupancy.
module riscv_hazard_ctrl_p #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_multicycle,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush,
  output logic              ex_hold,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int MC_W = 4;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              load;
  } slot_t;

  typedef struct packed {
    slot_t             s;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use1;
    logic              use2;
  } ex_slot_t;

  ex_slot_t        ex_q;
  slot_t           mem_q;
  slot_t           wb_q;
  logic [MC_W-1:0] mc_cnt;

  // x0 is hardwired to zero, so it can never be a real producer.
  function automatic logic writes(slot_t s, logic [REG_AW-1:0] r);
    return s.valid && s.wr && (s.rd == r) && (r != '0);
  endfunction

  function automatic logic id_depends(slot_t s, logic vld, logic u1, logic [REG_AW-1:0] r1,
                                      logic u2, logic [REG_AW-1:0] r2);
    return vld && ((u1 && writes(s, r1)) || (u2 && writes(s, r2)));
  endfunction

  function automatic logic [1:0] fwd_sel(logic used, logic [REG_AW-1:0] rs, slot_t m, slot_t w);
    if (used && writes(m, rs)) return 2'b10;
    if (used && writes(w, rs)) return 2'b01;
    return 2'b00;
  endfunction

  logic dep_ex, dep_mem, dep_wb, hazard, busy_raw, flush_raw, enter_ex;

  assign dep_ex  = id_depends(ex_q.s, id_valid, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
  assign dep_mem = id_depends(mem_q,  id_valid, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
  assign dep_wb  = id_depends(wb_q,   id_valid, id_use_rs1, id_rs1, id_use_rs2, id_rs2);

  assign hazard    = (FWD_EN != 0) ? (ex_q.s.load && dep_ex) : (dep_ex || dep_mem || dep_wb);
  assign busy_raw  = (mc_cnt != '0);
  assign flush_raw = ex_branch_taken && ex_q.s.valid && !busy_raw;

  // Outputs are forced quiet while reset is low, even before the first reset edge.
  assign mc_busy = reset && busy_raw;
  assign ex_hold = mc_busy;
  assign flush   = reset && flush_raw;
  assign stall   = reset && !flush_raw && (busy_raw || hazard);
  assign fwd_a   = (FWD_EN != 0 && reset && ex_q.s.valid)
                   ? fwd_sel(ex_q.use1, ex_q.rs1, mem_q, wb_q) : 2'b00;
  assign fwd_b   = (FWD_EN != 0 && reset && ex_q.s.valid)
                   ? fwd_sel(ex_q.use2, ex_q.rs2, mem_q, wb_q) : 2'b00;

  assign enter_ex = id_valid && !stall && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; WB <= MEM and MEM <= EX must see the old EX/MEM, not the new ones.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      mc_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_hold ? slot_t'('0) : ex_q.s;

      if (ex_hold) begin
        mc_cnt <= mc_cnt - 1'b1;
      end else if (enter_ex) begin
        ex_q.s.valid <= 1'b1;
        ex_q.s.rd    <= id_rd;
        ex_q.s.wr    <= id_reg_write;
        ex_q.s.load  <= id_mem_read;
        ex_q.rs1     <= id_rs1;
        ex_q.rs2     <= id_rs2;
        ex_q.use1    <= id_use_rs1;
        ex_q.use2    <= id_use_rs2;
        mc_cnt       <= id_multicycle ? MC_W'(MC_LAT - 1) : '0;
      end else begin
        ex_q   <= '0;
        mc_cnt <= '0;
      end

      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_hazard_ctrl_p.sv
// Self-checking bench: three configurations (forwarding, interlock, 4-bit counter) share one
// random instruction stream; each is compared every cycle to a queue-free stage-list model.
module tb_riscv_hazard_ctrl_p;

  localparam int AW  = 5;
  localparam int LAT = 4;

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
    bit mc;
    int rs1;
    int rs2;
    bit u1;
    bit u2;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic id_reg_write = 1'b0, id_mem_read = 1'b0, id_multicycle = 1'b0, ex_branch_taken = 1'b0;

  logic [2:0]  stall_o, flush_o, hold_o, busy_o;
  logic [1:0]  fa_o [3];
  logic [1:0]  fb_o [3];
  logic [15:0] cnt_f, cnt_i;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  riscv_hazard_ctrl_p #(.REG_AW(AW), .MC_LAT(LAT), .FWD_EN(1), .CNT_W(16)) dut_f (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
    .ex_branch_taken(ex_branch_taken), .stall(stall_o[0]), .flush(flush_o[0]),
    .ex_hold(hold_o[0]), .fwd_a(fa_o[0]), .fwd_b(fb_o[0]), .mc_busy(busy_o[0]),
    .stall_cnt(cnt_f));

  riscv_hazard_ctrl_p #(.REG_AW(AW), .MC_LAT(LAT), .FWD_EN(0), .CNT_W(16)) dut_i (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
    .ex_branch_taken(ex_branch_taken), .stall(stall_o[1]), .flush(flush_o[1]),
    .ex_hold(hold_o[1]), .fwd_a(fa_o[1]), .fwd_b(fb_o[1]), .mc_busy(busy_o[1]),
    .stall_cnt(cnt_i));

  riscv_hazard_ctrl_p #(.REG_AW(AW), .MC_LAT(LAT), .FWD_EN(1), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
    .ex_branch_taken(ex_branch_taken), .stall(stall_o[2]), .flush(flush_o[2]),
    .ex_hold(hold_o[2]), .fwd_a(fa_o[2]), .fwd_b(fb_o[2]), .mc_busy(busy_o[2]),
    .stall_cnt(cnt_s));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Model state per configuration: one record per occupied stage, EX residency age,
  // and total stall cycles since reset.
  rec_t   ex [3];
  rec_t   mem [3];
  rec_t   wb [3];
  int     occ [3];
  longint nstall [3];
  bit     primed = 1'b0;

  function automatic bit wr_hit(rec_t s, int r);
    return s.v && s.wr && s.rd == r && r != 0;
  endfunction

  function automatic bit id_dep(rec_t s);
    return id_valid && ((id_use_rs1 && wr_hit(s, int'(id_rs1))) ||
                        (id_use_rs2 && wr_hit(s, int'(id_rs2))));
  endfunction

  function automatic int fsel(bit u, int rs, rec_t m, rec_t w);
    if (u && wr_hit(m, rs)) return 2;
    if (u && wr_hit(w, rs)) return 1;
    return 0;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit     fwd  = (k != 1);
      bit     busy = ex[k].v && ex[k].mc && occ[k] < LAT;
      bit     fl   = ex_branch_taken && ex[k].v && !busy;
      bit     haz  = fwd ? (ex[k].ld && id_dep(ex[k]))
                         : (id_dep(ex[k]) || id_dep(mem[k]) || id_dep(wb[k]));
      bit     st   = !fl && (busy || haz);
      int     fa   = (fwd && ex[k].v) ? fsel(ex[k].u1, ex[k].rs1, mem[k], wb[k]) : 0;
      int     fb   = (fwd && ex[k].v) ? fsel(ex[k].u2, ex[k].rs2, mem[k], wb[k]) : 0;
      longint cmax = (k == 2) ? 15 : 65535;
      longint cact = (k == 0) ? longint'(cnt_f) : (k == 1) ? longint'(cnt_i) : longint'(cnt_s);
      rec_t   nr;
      if (!reset) begin
        busy = 0; fl = 0; st = 0; fa = 0; fb = 0;
      end
      check($sformatf("stall[%0d]", k),   stall_o[k], st);
      check($sformatf("flush[%0d]", k),   flush_o[k], fl);
      check($sformatf("ex_hold[%0d]", k), hold_o[k],  busy);
      check($sformatf("mc_busy[%0d]", k), busy_o[k],  busy);
      check($sformatf("fwd_a[%0d]", k),   fa_o[k],    fa);
      check($sformatf("fwd_b[%0d]", k),   fb_o[k],    fb);
      if (primed) check($sformatf("stall_cnt[%0d]", k), cact, (nstall[k] < cmax) ? nstall[k] : cmax);

      if (!reset) begin
        ex[k] = '{default: 0}; mem[k] = '{default: 0}; wb[k] = '{default: 0};
        occ[k] = 0; nstall[k] = 0;
      end else begin
        nstall[k] += st;
        wb[k] = mem[k];
        if (busy) begin
          mem[k] = '{default: 0};
          occ[k]++;
        end else begin
          mem[k] = ex[k];
          if (id_valid && !st && !fl) begin
            nr = '{v: 1, rd: int'(id_rd), wr: id_reg_write, ld: id_mem_read, mc: id_multicycle,
                   rs1: int'(id_rs1), rs2: int'(id_rs2), u1: id_use_rs1, u2: id_use_rs2};
            ex[k] = nr;
            occ[k] = 1;
          end else begin
            ex[k] = '{default: 0};
            occ[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    primed = 1'b1;
  endtask

  task automatic issue(input int rd, input int rs1, input int rs2, input bit wr, input bit ld,
                       input bit mc, input bit br, input int n);
    id_valid = 1'b1; id_rd = AW'(rd); id_rs1 = AW'(rs1); id_rs2 = AW'(rs2);
    id_use_rs1 = (rs1 >= 0); id_use_rs2 = (rs2 >= 0);
    id_reg_write = wr; id_mem_read = ld; id_multicycle = mc; ex_branch_taken = br;
    repeat (n) cycle();
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0; ex_branch_taken = 1'b0; id_multicycle = 1'b0; id_mem_read = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ex[k] = '{default: 0}; mem[k] = '{default: 0}; wb[k] = '{default: 0};
      occ[k] = 0; nstall[k] = 0;
    end
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);

    // add x5 ; add x6,x5,x1
    issue(5, 1, 2, 1, 0, 0, 0, 1);
    issue(6, 5, 1, 1, 0, 0, 0, 1);
    idle(4);
    // lw x7 ; add x8,x7,x7 (consumer held while stalled)
    issue(7, 1, -1, 1, 1, 0, 0, 1);
    issue(8, 7, 7, 1, 0, 0, 0, 4);
    idle(4);
    // mul x9 with a branch asserted during the busy window, then released
    issue(9, 1, 2, 1, 0, 1, 0, 1);
    issue(10, 9, -1, 1, 0, 0, 1, 3);
    issue(10, 9, -1, 1, 0, 0, 0, 2);
    idle(4);
    // load-use stall met by a taken branch in the same cycle
    issue(11, 1, -1, 1, 1, 0, 0, 1);
    issue(12, 11, -1, 1, 0, 0, 1, 1);
    idle(4);
    // reset in the middle of a multicycle op
    issue(13, 1, 2, 1, 0, 1, 0, 2);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(2);

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      id_valid        = ($urandom_range(0, 9) != 0);
      id_rd           = AW'($urandom_range(0, 3));
      id_rs1          = AW'($urandom_range(0, 3));
      id_rs2          = AW'($urandom_range(0, 3));
      id_use_rs1      = $urandom_range(0, 1);
      id_use_rs2      = $urandom_range(0, 1);
      id_reg_write    = ($urandom_range(0, 4) != 0);
      id_mem_read     = ($urandom_range(0, 3) == 0);
      id_multicycle   = ($urandom_range(0, 11) == 0);
      ex_branch_taken = ($urandom_range(0, 11) == 0);
      reset           = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1'b1;
    idle(3);

    // repeated load-use pairs push the 4-bit counter well past its ceiling
    for (int i = 0; i < 20; i++) begin
      issue(1, 2, -1, 1, 1, 0, 0, 1);
      issue(3, 1, -1, 1, 0, 0, 0, 2);
    end
    idle(1);
    check("cnt_saturated", cnt_s, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
